// File: rtl/fetch_pkg.sv
// Shared encodings, state type and opcode helper for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned INST_BITS = 9;
  localparam int unsigned LUT_IDX_W = 5;

  localparam logic [INST_BITS-1:0] NOP_INST   = 9'h1A0;
  localparam logic [INST_BITS-1:0] HALT_INST  = 9'h1FF;
  localparam logic [2:0]           BR_OPC_MAX = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Branch opcodes live in the upper half of the opcode space, sub-opcodes 0..3.
  function automatic logic is_branch(input logic [INST_BITS-1:0] inst);
    return inst[8] && (inst[7:5] <= BR_OPC_MAX);
  endfunction

endpackage

// File: rtl/inst_fetch_branch_lut.sv
// Branch-target register file: one synchronous write port, one combinational read port.
module branch_lut #(
  parameter int DEPTH = 32,
  parameter int W     = 10,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  // Contents are deliberately left unreset; software loads targets before use.
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // A same-cycle write is not forwarded: readers see the old entry this cycle.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch / PC unit: start/run/stall/halt sequencing with LUT-based branches.
// Optional RUN-cycle counter output is compiled in with FETCH_CYCLE_COUNT_EN.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int INST_W    = 9,
  parameter int LUT_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PC_W-1:0]      start_pc,
  input  logic                 stall,
  input  logic                 branch_en,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [INST_W-1:0]    imem_rdata,
  output logic [INST_W-1:0]    inst,
  output logic [PC_W-1:0]      pc,
  output logic                 running,
  output logic                 done,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
`ifdef FETCH_CYCLE_COUNT_EN
  output logic [15:0]          cycle_count,
`endif
  output fetch_state_t         dbg_state
);

  fetch_state_t    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            running_q;
  logic            done_q;
  logic [PC_W-1:0] lut_rdata;
  logic            take_branch;

  branch_lut #(
    .DEPTH (LUT_DEPTH),
    .W     (PC_W),
    .IDX_W (LUT_IDX_W)
  ) u_lut (
    .clk   (clk),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (imem_rdata[LUT_IDX_W-1:0]),
    .rdata (lut_rdata)
  );

  // branch_en from the decoder only counts when the fetched word really is a branch.
  always_comb begin
    take_branch = branch_en && is_branch(imem_rdata);
    pc_d        = pc_q + PC_W'(1);
    if (take_branch) begin
      pc_d = lut_rdata;
    end
  end

  // start is a one-cycle pulse honoured only from IDLE or HALT; in RUN it is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (start) begin
            state_q   <= RUN;
            pc_q      <= start_pc;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (imem_rdata == HALT_INST) begin
              state_q   <= HALT;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              pc_q <= pc_d;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          pc_q      <= '0;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cycle_cnt_q;

  // Counts every RUN cycle including stalls, saturating; frozen outside RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
    end else if (start && (state_q != RUN)) begin
      cycle_cnt_q <= '0;
    end else if ((state_q == RUN) && (cycle_cnt_q != 16'hFFFF)) begin
      cycle_cnt_q <= cycle_cnt_q + 16'd1;
    end
  end

  assign cycle_count = cycle_cnt_q;
`endif

  // A stalled slot shows NOP; the held PC re-presents the same word once released.
  assign inst      = ((state_q == RUN) && !stall) ? imem_rdata : NOP_INST;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign running   = running_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
